// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_if
// Desc   : IFU/LSU request-response channels and the shared memory channel.
// Rev    : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    if_req_valid;
    logic                    if_req_ready;
    logic [ADDR_WIDTH-1:0]   if_req_addr;
    logic                    if_rsp_valid;
    logic                    if_rsp_ready;
    logic [DATA_WIDTH-1:0]   if_rsp_rdata;

    logic                    ls_req_valid;
    logic                    ls_req_ready;
    logic [ADDR_WIDTH-1:0]   ls_req_addr;
    logic                    ls_req_wen;
    logic [DATA_WIDTH-1:0]   ls_req_wdata;
    logic [DATA_WIDTH/8-1:0] ls_req_wmask;
    logic                    ls_rsp_valid;
    logic                    ls_rsp_ready;
    logic [DATA_WIDTH-1:0]   ls_rsp_rdata;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_req_wen;
    logic [DATA_WIDTH-1:0]   mem_req_wdata;
    logic [DATA_WIDTH/8-1:0] mem_req_wmask;
    logic                    mem_rsp_valid;
    logic                    mem_rsp_ready;
    logic [DATA_WIDTH-1:0]   mem_rsp_rdata;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_req_addr, if_rsp_ready,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready
    );

    // Environment side (masters and memory)
    modport master (
        output if_req_valid, if_req_addr, if_rsp_ready,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Desc   : Round-robin IFU/LSU arbiter onto one memory port, one txn in flight.
// Rev    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus,
    output logic           busy
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  grant;       // 1 = LSU owns the current transaction
    logic                  last_grant;  // 1 = LSU
    logic                  win_valid;
    logic                  win_ls;
    logic                  rsp_done;
    logic                  granted_rsp_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_wen;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_WIDTH-1:0] req_wmask;

    always_comb begin
        state_nxt         = state;
        win_valid         = bus.if_req_valid | bus.ls_req_valid;
        // Sole requester wins; on contention the master not served last wins
        win_ls            = bus.ls_req_valid & (~bus.if_req_valid | ~last_grant);
        granted_rsp_ready = grant ? bus.ls_rsp_ready : bus.if_rsp_ready;
        rsp_done          = 1'b0;
        bus.if_req_ready  = 1'b0;
        bus.ls_req_ready  = 1'b0;
        bus.mem_rsp_ready = 1'b0;
        bus.if_rsp_valid  = 1'b0;
        bus.ls_rsp_valid  = 1'b0;
        bus.if_rsp_rdata  = '0;
        bus.ls_rsp_rdata  = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so readies drop the moment reset asserts
                bus.if_req_ready = rst_n & win_valid & ~win_ls;
                bus.ls_req_ready = rst_n & win_valid & win_ls;
                if (win_valid) state_nxt = REQ;
            end
            REQ: begin
                if (bus.mem_req_ready) state_nxt = RSP;
            end
            RSP: begin
                bus.mem_rsp_ready = granted_rsp_ready;
                rsp_done          = bus.mem_rsp_valid & granted_rsp_ready;
                if (grant) begin
                    bus.ls_rsp_valid = bus.mem_rsp_valid;
                    bus.ls_rsp_rdata = bus.mem_rsp_rdata;
                end else begin
                    bus.if_rsp_valid = bus.mem_rsp_valid;
                    bus.if_rsp_rdata = bus.mem_rsp_rdata;
                end
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            req_addr   <= '0;
            req_wen    <= 1'b0;
            req_wdata  <= '0;
            req_wmask  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_valid) begin
                grant     <= win_ls;
                req_addr  <= win_ls ? bus.ls_req_addr : bus.if_req_addr;
                req_wen   <= win_ls & bus.ls_req_wen;
                req_wdata <= win_ls ? bus.ls_req_wdata : '0;
                req_wmask <= win_ls ? bus.ls_req_wmask : '0;
            end
            if (rsp_done) last_grant <= grant;
        end
    end

    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_req_wen   = req_wen;
    assign bus.mem_req_wdata = req_wdata;
    assign bus.mem_req_wmask = req_wmask;
    assign busy              = (state != IDLE);

endmodule
`default_nettype wire
